// File: rtl/sim_run_ctrl.sv
// Run sequencer for simulation tops: DUT reset hold, run-cycle count,
// heartbeat strobe, cycle-budget timeout, drain and finish request.
module sim_run_ctrl #(
    parameter int CNT_W        = 32,
    parameter int RST_CYCLES   = 11,
    parameter int MAX_CYCLES   = 1000,
    parameter int HB_PERIOD    = 100,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             test_done_i,
    input  logic             abort_i,
    output logic             dut_rst_n_o,
    output logic             run_o,
    output logic             heartbeat_o,
    output logic             finish_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [2:0]       state_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RST_HOLD = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_DRAIN    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_TIMEOUT  = 3'd5;

    // Zero-length hold/drain would be meaningless; they collapse to one clock.
    localparam int RC_EFF = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
    localparam int DC_EFF = (DRAIN_CYCLES == 0) ? 1 : DRAIN_CYCLES;

    localparam logic [31:0] HOLD_LAST  = 32'(RC_EFF - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(DC_EFF - 1);
    localparam logic [31:0] HB_LAST    = 32'(HB_PERIOD - 1);

    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);

    logic [2:0]       state_q, state_d;
    logic [31:0]      hold_q, hold_d;
    logic [31:0]      drain_q, drain_d;
    logic [31:0]      hb_q, hb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hb_pulse;

    // Next-state, counter and heartbeat decode.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        drain_d  = drain_q;
        hb_d     = hb_q;
        cnt_d    = cnt_q;
        hb_pulse = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
            hold_d  = '0;
            drain_d = '0;
            hb_d    = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (start_i) begin
                        state_d = S_RST_HOLD;
                        hold_d  = '0;
                        drain_d = '0;
                        hb_d    = '0;
                        cnt_d   = '0;
                    end
                end
                S_RST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_RUN;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 32'd1;
                    end
                end
                S_RUN: begin
                    if (test_done_i) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else if (MAX_CYCLES != 0 && cnt_q == MAX_C) begin
                        state_d = S_TIMEOUT;
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 1'b1;
                        if (HB_PERIOD != 0) begin
                            if (hb_q == HB_LAST) begin
                                hb_d     = '0;
                                hb_pulse = 1'b1;
                            end else begin
                                hb_d = hb_q + 32'd1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        drain_d = drain_q + 32'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            drain_q     <= '0;
            hb_q        <= '0;
            cnt_q       <= '0;
            dut_rst_n_o <= 1'b0;
            run_o       <= 1'b0;
            heartbeat_o <= 1'b0;
            finish_o    <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            drain_q     <= drain_d;
            hb_q        <= hb_d;
            cnt_q       <= cnt_d;
            dut_rst_n_o <= (state_d == S_RUN) || (state_d == S_DRAIN) ||
                           (state_d == S_DONE);
            run_o       <= (state_d == S_RUN);
            heartbeat_o <= hb_pulse;
            finish_o    <= (state_d == S_DONE) || (state_d == S_TIMEOUT);
            timeout_o   <= (state_d == S_TIMEOUT);
        end
    end

    assign cycle_cnt_o = cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed self-checking bench for sim_run_ctrl: three instances cover
// defaults, a short budget, and an 8-bit counter with timeout disabled.
module tb_sim_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0, done0, abort0;
    logic start1, done1, abort1;
    logic start2, done2, abort2;

    logic rn0, run0, hb0, fin0, to0;
    logic rn1, run1, hb1, fin1, to1;
    logic rn2, run2, hb2, fin2, to2;
    logic [31:0] cnt0, cnt1;
    logic [7:0]  cnt2;
    logic [2:0]  st0, st1, st2;

    int total = 0;
    int bad   = 0;

    sim_run_ctrl u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0),
        .test_done_i(done0), .abort_i(abort0),
        .dut_rst_n_o(rn0), .run_o(run0), .heartbeat_o(hb0),
        .finish_o(fin0), .timeout_o(to0),
        .cycle_cnt_o(cnt0), .state_o(st0)
    );

    sim_run_ctrl #(.MAX_CYCLES(50)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1),
        .test_done_i(done1), .abort_i(abort1),
        .dut_rst_n_o(rn1), .run_o(run1), .heartbeat_o(hb1),
        .finish_o(fin1), .timeout_o(to1),
        .cycle_cnt_o(cnt1), .state_o(st1)
    );

    sim_run_ctrl #(.CNT_W(8), .MAX_CYCLES(0)) u2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2),
        .test_done_i(done2), .abort_i(abort2),
        .dut_rst_n_o(rn2), .run_o(run2), .heartbeat_o(hb2),
        .finish_o(fin2), .timeout_o(to2),
        .cycle_cnt_o(cnt2), .state_o(st2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {start0, done0, abort0} = '0;
        {start1, done1, abort1} = '0;
        {start2, done2, abort2} = '0;
        repeat (3) tick();
        total++;
        if ({st0, rn0, run0, hb0, fin0, to0, cnt0} !== '0) begin
            bad++;
            $display("FAIL reset_u0 st=%0d rn=%b run=%b fin=%b to=%b cnt=%0d want all 0",
                     st0, rn0, run0, fin0, to0, cnt0);
        end
        total++;
        if ({st1, rn1, run1, hb1, fin1, to1, cnt1} !== '0) begin
            bad++;
            $display("FAIL reset_u1 st=%0d cnt=%0d want all 0", st1, cnt1);
        end
        total++;
        if ({st2, rn2, run2, hb2, fin2, to2, cnt2} !== '0) begin
            bad++;
            $display("FAIL reset_u2 st=%0d cnt=%0d want all 0", st2, cnt2);
        end
        rst = 1'b0;
        repeat (2) tick();
        total++;
        if (st0 !== 3'd0 || rn0 !== 1'b0) begin
            bad++;
            $display("FAIL idle_u0 st=%0d rn=%b want 0 0", st0, rn0);
        end
    endtask

    task automatic test_start_hold0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        total++;
        if (st0 !== 3'd1 || rn0 !== 1'b0 || cnt0 !== 32'd0) begin
            bad++;
            $display("FAIL hold_enter st=%0d rn=%b cnt=%0d want 1 0 0", st0, rn0, cnt0);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if (rn0 !== 1'b0 || run0 !== 1'b0 || st0 !== 3'd1) begin
                bad++;
                $display("FAIL hold_edge%0d st=%0d rn=%b want 1 0", i, st0, rn0);
            end
        end
        tick();
        total++;
        if (rn0 !== 1'b1 || run0 !== 1'b1 || st0 !== 3'd2 || cnt0 !== 32'd0) begin
            bad++;
            $display("FAIL hold_release st=%0d rn=%b run=%b cnt=%0d want 2 1 1 0",
                     st0, rn0, run0, cnt0);
        end
    endtask

    task automatic test_timeout0();
        int hbs;
        int hb_err;
        hbs = 0;
        hb_err = 0;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if (hb0 === 1'b1) hbs++;
            if (hb0 !== ((i % 100) == 0)) hb_err++;
        end
        total++;
        if (cnt0 !== 32'd1000 || st0 !== 3'd2 || to0 !== 1'b0) begin
            bad++;
            $display("FAIL budget_reach cnt=%0d st=%0d to=%b want 1000 2 0", cnt0, st0, to0);
        end
        total++;
        if (hbs !== 10 || hb_err !== 0) begin
            bad++;
            $display("FAIL heartbeat pulses=%0d misplaced=%0d want 10 0", hbs, hb_err);
        end
        tick();
        total++;
        if (st0 !== 3'd5 || to0 !== 1'b1 || fin0 !== 1'b1 || rn0 !== 1'b0 ||
            run0 !== 1'b0 || cnt0 !== 32'd1000) begin
            bad++;
            $display("FAIL timeout st=%0d to=%b fin=%b rn=%b run=%b cnt=%0d want 5 1 1 0 0 1000",
                     st0, to0, fin0, rn0, run0, cnt0);
        end
        repeat (3) tick();
        total++;
        if (st0 !== 3'd5 || cnt0 !== 32'd1000 || fin0 !== 1'b1) begin
            bad++;
            $display("FAIL timeout_hold st=%0d cnt=%0d fin=%b want 5 1000 1", st0, cnt0, fin0);
        end
    endtask

    task automatic test_done_drain0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        total++;
        if (st0 !== 3'd1 || fin0 !== 1'b0 || to0 !== 1'b0 || cnt0 !== 32'd0) begin
            bad++;
            $display("FAIL restart_clear st=%0d fin=%b to=%b cnt=%0d want 1 0 0 0",
                     st0, fin0, to0, cnt0);
        end
        repeat (11) tick();
        repeat (100) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        total++;
        if (st0 !== 3'd2 || cnt0 !== 32'd101) begin
            bad++;
            $display("FAIL start_in_run st=%0d cnt=%0d want 2 101", st0, cnt0);
        end
        repeat (149) tick();
        total++;
        if (cnt0 !== 32'd250) begin
            bad++;
            $display("FAIL run_cnt cnt=%0d want 250", cnt0);
        end
        done0 = 1'b1;
        tick();
        done0 = 1'b0;
        total++;
        if (st0 !== 3'd3 || run0 !== 1'b0 || rn0 !== 1'b1 || cnt0 !== 32'd250) begin
            bad++;
            $display("FAIL drain_enter st=%0d run=%b rn=%b cnt=%0d want 3 0 1 250",
                     st0, run0, rn0, cnt0);
        end
        repeat (15) tick();
        total++;
        if (st0 !== 3'd3 || fin0 !== 1'b0) begin
            bad++;
            $display("FAIL drain_len st=%0d fin=%b want 3 0", st0, fin0);
        end
        tick();
        total++;
        if (st0 !== 3'd4 || fin0 !== 1'b1 || to0 !== 1'b0 || cnt0 !== 32'd250 ||
            rn0 !== 1'b1) begin
            bad++;
            $display("FAIL done st=%0d fin=%b to=%b cnt=%0d rn=%b want 4 1 0 250 1",
                     st0, fin0, to0, cnt0, rn0);
        end
    endtask

    task automatic test_same_cycle1();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (11) tick();
        repeat (50) tick();
        total++;
        if (cnt1 !== 32'd50 || st1 !== 3'd2) begin
            bad++;
            $display("FAIL budget50 cnt=%0d st=%0d want 50 2", cnt1, st1);
        end
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        total++;
        if (st1 !== 3'd3 || to1 !== 1'b0 || fin1 !== 1'b0) begin
            bad++;
            $display("FAIL done_vs_budget st=%0d to=%b fin=%b want 3 0 0", st1, to1, fin1);
        end
    endtask

    task automatic test_abort_restart1();
        repeat (3) tick();
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        total++;
        if ({st1, rn1, run1, hb1, fin1, to1, cnt1} !== '0) begin
            bad++;
            $display("FAIL abort st=%0d rn=%b run=%b cnt=%0d want all 0", st1, rn1, run1, cnt1);
        end
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if (rn1 !== 1'b0 || st1 !== 3'd1) begin
                bad++;
                $display("FAIL rehold_edge%0d st=%0d rn=%b want 1 0", i, st1, rn1);
            end
        end
        tick();
        total++;
        if (rn1 !== 1'b1 || st1 !== 3'd2 || cnt1 !== 32'd0) begin
            bad++;
            $display("FAIL rehold_release st=%0d rn=%b cnt=%0d want 2 1 0", st1, rn1, cnt1);
        end
        tick();
        total++;
        if (cnt1 !== 32'd1) begin
            bad++;
            $display("FAIL recount cnt=%0d want 1", cnt1);
        end
    endtask

    task automatic test_async_sat2();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (11) tick();
        repeat (20) tick();
        total++;
        if (st2 !== 3'd2 || cnt2 !== 8'd20) begin
            bad++;
            $display("FAIL pre_async st=%0d cnt=%0d want 2 20", st2, cnt2);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({st2, rn2, run2, hb2, fin2, to2, cnt2} !== '0) begin
            bad++;
            $display("FAIL async_rst st=%0d rn=%b run=%b cnt=%0d want all 0", st2, rn2, run2, cnt2);
        end
        start2 = 1'b1;
        repeat (2) tick();
        total++;
        if (st2 !== 3'd0) begin
            bad++;
            $display("FAIL start_in_rst st=%0d want 0", st2);
        end
        start2 = 1'b0;
        #2;
        rst = 1'b0;
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (11) tick();
        repeat (300) tick();
        total++;
        if (cnt2 !== 8'd255 || st2 !== 3'd2 || to2 !== 1'b0 || run2 !== 1'b1) begin
            bad++;
            $display("FAIL saturate cnt=%0d st=%0d to=%b run=%b want 255 2 0 1",
                     cnt2, st2, to2, run2);
        end
    endtask

    initial begin
        test_reset();
        test_start_hold0();
        test_timeout0();
        test_done_drain0();
        test_same_cycle1();
        test_abort_restart1();
        test_async_sat2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
